stack_line_transfer_engine: RTL

// - Spill/fill engine directly downstream of the stack cache: services its line-out (spill) and line-in (fill) requests.
// - Serialises a dirty 256-bit stack cache line into bus beats on a narrow memory request channel (spill).
// - Deserialises returning read beats into a full line for the cache (fill).
// - One transfer at a time; spill has priority so a dirty line reaches memory before any refetch.

---
 rtl/stack_xfer_pkg.sv | 24 ++
 rtl/stack_line_deserializer.sv | 64 ++++++
 rtl/stack_line_transfer_engine.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/stack_xfer_pkg.sv
// Shared types and helpers for the stack cache spill/fill engine.
// Holds the transfer state encoding, default geometry and the beat address offset helper.
package stack_xfer_pkg;

  localparam int CACHELINEBYTESIZE_DEF = 32;
  localparam int BUSBITWIDTH_DEF       = 32;
  localparam int ADDRBITWIDTH_DEF      = 32;
  localparam int BEATS                 = (CACHELINEBYTESIZE_DEF * 8) / BUSBITWIDTH_DEF;
  localparam int BEAT_IDX_W            = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE,
    SPILL,
    FILL,
    DONE
  } xferState_t;

  // Byte offset of a beat from the line base address.
  function automatic int unsigned beatOffset(input int unsigned beatIdx,
                                             input int unsigned beatBytes);
    return beatIdx * beatBytes;
  endfunction

endpackage

// File: rtl/stack_line_deserializer.sv
// Fill-side receive path: counts returning read beats and assembles them into a full line.
// The assembled line is published on the same edge that accepts the last beat.
module stack_line_deserializer
  import stack_xfer_pkg::*;
#(
  parameter int LINEW = 256,
  parameter int BUSW  = 32
) (
  input  logic             clk,
  input  logic             async_rst,
  input  logic             clkEn,
  input  logic             active,
  input  logic             respValid,
  input  logic [BUSW-1:0]  respData,
  output logic             lineDone,
  output logic [LINEW-1:0] fillLine
);

  localparam int lineBeats = LINEW / BUSW;
  localparam int idxW      = $clog2(lineBeats);

  logic [idxW-1:0]  rxIdx;
  logic             rxDone;
  logic             take;
  logic [LINEW-1:0] assemblyLine;
  logic [LINEW-1:0] mergedLine;

  // Beats outside an active fill or past the last slot are dropped.
  assign take     = clkEn && active && respValid && !rxDone;
  assign lineDone = take && (rxIdx == idxW'(lineBeats - 1));

  always_comb begin
    // NOTE: assign the full default before the partial overwrite so no latch is inferred.
    mergedLine = assemblyLine;
    mergedLine[int'(rxIdx)*BUSW +: BUSW] = respData;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      rxIdx    <= '0;
      rxDone   <= 1'b0;
      fillLine <= '0;
    end else if (clkEn) begin
      if (!active) begin
        rxIdx  <= '0;
        rxDone <= 1'b0;
      end else if (take) begin
        if (lineDone) begin
          rxDone   <= 1'b1;
          fillLine <= mergedLine;
        end else begin
          rxIdx <= rxIdx + 1'b1;
        end
      end
    end
  end

  // NOTE: the assembly register is datapath storage; every slot is rewritten before it is published, so it has no reset.
  always_ff @(posedge clk) begin
    if (take) assemblyLine <= mergedLine;
  end

endmodule

// File: rtl/stack_line_transfer_engine.sv
// Stack cache spill/fill engine: serialises dirty lines to memory and refills lines beat by beat.
// Optional address bound checking is enabled with STACK_LINE_XFER_BOUND_CHECK_EN.
module stack_line_transfer_engine
  import stack_xfer_pkg::*;
#(
  parameter int CACHELINEBYTESIZE = CACHELINEBYTESIZE_DEF,
  parameter int CACHELINEBITWIDTH = CACHELINEBYTESIZE * 8,
  parameter int BUSBITWIDTH       = BUSBITWIDTH_DEF,
  parameter int ADDRBITWIDTH      = ADDRBITWIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         async_rst,
  input  logic                         clk_en,
  input  logic                         SpillREQ,
  input  logic [ADDRBITWIDTH-1:0]      SpillAddr,
  input  logic [CACHELINEBITWIDTH-1:0] SpillData,
  output logic                         SpillACK,
  input  logic                         FillREQ,
  input  logic [ADDRBITWIDTH-1:0]      FillAddr,
  output logic [CACHELINEBITWIDTH-1:0] FillData,
  output logic                         FillACK,
  output logic                         MemReqValid,
  input  logic                         MemReqReady,
  output logic                         MemReqWrite,
  output logic [ADDRBITWIDTH-1:0]      MemReqAddr,
  output logic [BUSBITWIDTH-1:0]       MemReqData,
  input  logic                         MemRespValid,
  input  logic [BUSBITWIDTH-1:0]       MemRespData,
`ifdef STACK_LINE_XFER_BOUND_CHECK_EN
  input  logic [ADDRBITWIDTH-1:0]      StackUpperBound,
  input  logic [ADDRBITWIDTH-1:0]      StackLowerBound,
  output logic                         XferFault,
`endif
  output logic                         Busy
);

  localparam int lineBeats = CACHELINEBITWIDTH / BUSBITWIDTH;
  localparam int idxW      = $clog2(lineBeats);

  xferState_t                 state, stateNext;
  logic                       isSpill;
  logic [ADDRBITWIDTH-1:0]    baseAddr;
  logic [CACHELINEBITWIDTH-1:0] spillLine;
  logic [idxW-1:0]            issueIdx;
  logic                       issueDone;
  logic                       issueLast;
  logic                       reqFire;
  logic                       accept;
  logic                       boundFault;
  logic                       rxLast;
  logic [ADDRBITWIDTH-1:0]    acceptAddr;
  logic [ADDRBITWIDTH-1:0]    alignedAddr;

  assign accept      = (state == IDLE) && (SpillREQ || FillREQ);
  assign acceptAddr  = SpillREQ ? SpillAddr : FillAddr;
  assign alignedAddr = acceptAddr & ~ADDRBITWIDTH'(CACHELINEBYTESIZE - 1);
  assign issueLast   = (issueIdx == idxW'(lineBeats - 1));
  assign reqFire     = clk_en && MemReqValid && MemReqReady;

`ifdef STACK_LINE_XFER_BOUND_CHECK_EN
  logic                    faultLatched;
  logic [ADDRBITWIDTH:0]   lineEnd;

  // Widened by one bit so a line near the top of the address space cannot wrap past the bound.
  assign lineEnd    = {1'b0, alignedAddr} + (ADDRBITWIDTH + 1)'(CACHELINEBYTESIZE - 1);
  assign boundFault = (alignedAddr < StackLowerBound) || (lineEnd > {1'b0, StackUpperBound});
  assign XferFault  = (state == DONE) && faultLatched;

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst)             faultLatched <= 1'b0;
    else if (clk_en && accept) faultLatched <= boundFault;
  end
`else
  assign boundFault = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (clk_en && SpillREQ)     stateNext = boundFault ? DONE : SPILL;
        else if (clk_en && FillREQ) stateNext = boundFault ? DONE : FILL;
      end
      SPILL:   if (reqFire && issueLast) stateNext = DONE;
      FILL:    if (rxLast)               stateNext = DONE;
      DONE:    if (clk_en)               stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state     <= IDLE;
      isSpill   <= 1'b0;
      baseAddr  <= '0;
      issueIdx  <= '0;
      issueDone <= 1'b0;
    end else if (clk_en) begin
      state <= stateNext;
      if (accept) begin
        isSpill   <= SpillREQ;
        baseAddr  <= alignedAddr;
        issueIdx  <= '0;
        issueDone <= 1'b0;
      end else if (MemReqValid && MemReqReady) begin
        if (issueLast) issueDone <= 1'b1;
        else           issueIdx  <= issueIdx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && accept && SpillREQ) spillLine <= SpillData;
  end

  assign MemReqValid = (state == SPILL) || ((state == FILL) && !issueDone);
  assign MemReqWrite = (state == SPILL);
  assign MemReqAddr  = MemReqValid
                     ? baseAddr + ADDRBITWIDTH'(beatOffset(int'(issueIdx), BUSBITWIDTH / 8))
                     : '0;
  assign MemReqData  = (state == SPILL) ? spillLine[int'(issueIdx)*BUSBITWIDTH +: BUSBITWIDTH] : '0;

  assign SpillACK = (state == DONE) && isSpill;
  assign FillACK  = (state == DONE) && !isSpill;
  assign Busy     = (state != IDLE);

  stack_line_deserializer #(
    .LINEW (CACHELINEBITWIDTH),
    .BUSW  (BUSBITWIDTH)
  ) u_deser (
    .clk       (clk),
    .async_rst (async_rst),
    .clkEn     (clk_en),
    .active    (state == FILL),
    .respValid (MemRespValid),
    .respData  (MemRespData),
    .lineDone  (rxLast),
    .fillLine  (FillData)
  );

endmodule
